// File: rtl/fetch_queue.sv
// Fetch stage: owns the fetch PC, masters the instruction bus with at most one
// request outstanding, and buffers fetched instructions for decode in a FIFO.
module fetch_queue #(
  parameter int              XLEN     = 64,
  parameter int              ILEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic                   ireq_valid,
  output logic [XLEN-1:0]        ireq_addr,
  input  logic                   ireq_ack,
  input  logic                   iresp_valid,
  input  logic [ILEN-1:0]        iresp_data,
  output logic                   out_valid,
  output logic [XLEN-1:0]        out_pc,
  output logic [ILEN-1:0]        out_instr,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic            drop_pending_q, drop_pending_d;
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] redirect_target;
  logic            push, pop;

  logic [XLEN-1:0] mem_pc    [DEPTH];
  logic [ILEN-1:0] mem_instr [DEPTH];

  assign redirect_target = redirect_pc & ~XLEN'(3);
  // A redirect kills both the response landing this cycle and any pop by decode.
  assign push = (state_q == S_WAIT) && iresp_valid && !redirect_valid;
  assign pop  = (count_q != '0) && out_ready && !redirect_valid;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (redirect_valid) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + 1'b1;
      if (pop)  head_d = head_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_comb begin
    state_d        = state_q;
    fetch_pc_d     = fetch_pc_q;
    req_addr_d     = req_addr_q;
    drop_pending_d = drop_pending_q;
    case (state_q)
      S_IDLE: begin
        if (redirect_valid) begin
          fetch_pc_d = redirect_target;
        end else if (count_q < FULL) begin
          state_d    = S_REQ;
          req_addr_d = fetch_pc_q;
        end
      end
      S_REQ: begin
        // The bus cannot take back a presented request, so a redirect here
        // only marks the eventual response for dropping.
        if (redirect_valid) fetch_pc_d = redirect_target;
        if (ireq_ack) begin
          drop_pending_d = 1'b0;
          if (redirect_valid || drop_pending_q) begin
            state_d = S_DROP;
          end else begin
            state_d    = S_WAIT;
            fetch_pc_d = fetch_pc_q + XLEN'(4);
          end
        end else if (redirect_valid) begin
          drop_pending_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          fetch_pc_d = redirect_target;
          state_d    = iresp_valid ? S_IDLE : S_DROP;
        end else if (iresp_valid) begin
          if (count_d < FULL) begin
            state_d    = S_REQ;
            req_addr_d = fetch_pc_q;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DROP: begin
        if (redirect_valid) fetch_pc_d = redirect_target;
        if (iresp_valid)    state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      fetch_pc_q     <= RESET_PC;
      req_addr_q     <= RESET_PC;
      drop_pending_q <= 1'b0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
    end else begin
      state_q        <= state_d;
      fetch_pc_q     <= fetch_pc_d;
      req_addr_q     <= req_addr_d;
      drop_pending_q <= drop_pending_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[tail_q]    <= req_addr_q;
      mem_instr[tail_q] <= iresp_data;
    end
  end

  assign ireq_valid = (state_q == S_REQ);
  assign ireq_addr  = req_addr_q;
  assign out_valid  = (count_q != '0);
  assign out_pc     = out_valid ? mem_pc[head_q]    : '0;
  assign out_instr  = out_valid ? mem_instr[head_q] : '0;
  assign count      = count_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(iresp_valid && (state_q == S_IDLE || state_q == S_REQ)))
        else $error("iresp_valid with no request outstanding");
    end
  end
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus a randomized bus/decode/redirect
// run checked against a queue-based model of the fetch stream.
`timescale 1ns/1ps
module tb_fetch_queue;
  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [63:0] RESET_PC = 64'h8000_0000;

  logic            clk = 1'b0;
  logic            reset, redirect_valid, ireq_ack, iresp_valid, out_ready;
  logic [63:0]     redirect_pc, ireq_addr, out_pc;
  logic            ireq_valid, out_valid;
  logic [31:0]     iresp_data, out_instr;
  logic [CW-1:0]   count;

  int n_cmp = 0;
  int n_bad = 0;
  bit          bus_pend;
  logic [63:0] bus_addr;
  int          bus_nreq;

  always #5 clk = ~clk;

  fetch_queue #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr), .ireq_ack(ireq_ack),
    .iresp_valid(iresp_valid), .iresp_data(iresp_data),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
    .out_ready(out_ready), .count(count)
  );

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return 32'h13 ^ {a[27:0], 4'h0};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    redirect_valid = 0; redirect_pc = '0; ireq_ack = 0; iresp_valid = 0;
    iresp_data = '0; out_ready = 0; bus_pend = 0; bus_addr = '0; bus_nreq = 0;
    reset = 1;
    tick(); tick();
    reset = 0;
  endtask

  // Well-behaved bus: acks every request at once, answers one cycle later.
  task automatic bus_run(input int n);
    for (int i = 0; i < n; i++) begin
      iresp_valid = bus_pend;
      iresp_data  = instr_of(bus_addr);
      ireq_ack    = 1;
      if (ireq_valid) begin
        bus_nreq++;
        bus_addr = ireq_addr;
      end
      bus_pend = ireq_valid;
      tick();
    end
    ireq_ack = 0;
    iresp_valid = 0;
  endtask

  task automatic test_reset();
    redirect_valid = 0; redirect_pc = '0; ireq_ack = 1; iresp_valid = 0;
    iresp_data = '0; out_ready = 1; reset = 1;
    tick(); tick();
    n_cmp++; if (ireq_valid !== 1'b0) begin n_bad++; $display("FAIL reset_ireq_valid: got %b expected 0", ireq_valid); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (count !== '0) begin n_bad++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_cmp++; if (out_pc !== '0) begin n_bad++; $display("FAIL reset_out_pc: got %h expected 0", out_pc); end
    n_cmp++; if (out_instr !== '0) begin n_bad++; $display("FAIL reset_out_instr: got %h expected 0", out_instr); end
    ireq_ack = 0; reset = 0;
    tick();
    n_cmp++; if (ireq_valid !== 1'b1 || ireq_addr !== RESET_PC) begin n_bad++; $display("FAIL reset_first_req: got v=%b a=%h expected v=1 a=%h", ireq_valid, ireq_addr, RESET_PC); end
  endtask

  task automatic test_stream();
    logic [63:0] exp_req, exp_out, pend_addr;
    bit pend;
    int first_out, nout, nreq;
    do_reset();
    out_ready = 1; ireq_ack = 1;
    exp_req = RESET_PC; exp_out = RESET_PC; pend = 0; pend_addr = '0;
    first_out = 0; nout = 0; nreq = 0;
    for (int c = 1; c <= 24; c++) begin
      tick();
      if (out_valid) begin
        if (first_out == 0) first_out = c;
        n_cmp++; if (out_pc !== exp_out) begin n_bad++; $display("FAIL stream_out_pc: got %h expected %h", out_pc, exp_out); end
        n_cmp++; if (out_instr !== instr_of(exp_out)) begin n_bad++; $display("FAIL stream_out_instr: got %h expected %h", out_instr, instr_of(exp_out)); end
        exp_out += 4; nout++;
      end
      if (ireq_valid) begin
        n_cmp++; if (ireq_addr !== exp_req) begin n_bad++; $display("FAIL stream_req_addr: got %h expected %h", ireq_addr, exp_req); end
        exp_req += 4; nreq++;
      end
      iresp_valid = pend;
      iresp_data = instr_of(pend_addr);
      pend = ireq_valid;
      pend_addr = ireq_addr;
    end
    iresp_valid = 0; ireq_ack = 0;
    n_cmp++; if (first_out !== 3) begin n_bad++; $display("FAIL stream_latency: got %0d expected 3", first_out); end
    n_cmp++; if (nreq !== 12) begin n_bad++; $display("FAIL stream_req_count: got %0d expected 12", nreq); end
    n_cmp++; if (nout !== 11) begin n_bad++; $display("FAIL stream_out_count: got %0d expected 11", nout); end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus_run(30);
    n_cmp++; if (bus_nreq !== DEPTH) begin n_bad++; $display("FAIL bp_fill_reqs: got %0d expected %0d", bus_nreq, DEPTH); end
    n_cmp++; if (count !== CW'(DEPTH)) begin n_bad++; $display("FAIL bp_full_count: got %0d expected %0d", count, DEPTH); end
    n_cmp++; if (ireq_valid !== 1'b0) begin n_bad++; $display("FAIL bp_req_idle: got %b expected 0", ireq_valid); end
    out_ready = 1;
    tick();
    out_ready = 0;
    n_cmp++; if (out_pc !== RESET_PC + 64'd4) begin n_bad++; $display("FAIL bp_pop_pc: got %h expected %h", out_pc, RESET_PC + 64'd4); end
    bus_nreq = 0;
    bus_run(20);
    n_cmp++; if (bus_nreq !== 1) begin n_bad++; $display("FAIL bp_one_more: got %0d expected 1", bus_nreq); end
    n_cmp++; if (count !== CW'(DEPTH)) begin n_bad++; $display("FAIL bp_refill_count: got %0d expected %0d", count, DEPTH); end
  endtask

  task automatic test_redirect_req();
    do_reset();
    for (int i = 0; i < 10 && count != 1; i++) bus_run(1);
    n_cmp++; if (count !== 1 || ireq_valid !== 1'b1) begin n_bad++; $display("FAIL rreq_setup: got count=%0d v=%b expected 1 1", count, ireq_valid); end
    redirect_valid = 1; redirect_pc = 64'h8000_0103;
    tick();
    redirect_valid = 0;
    n_cmp++; if (count !== 0) begin n_bad++; $display("FAIL rreq_flush: got %0d expected 0", count); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (ireq_valid !== 1'b1 || ireq_addr !== RESET_PC + 64'd4) begin n_bad++; $display("FAIL rreq_hold: got v=%b a=%h expected v=1 a=%h", ireq_valid, ireq_addr, RESET_PC + 64'd4); end
      if (i == 2) ireq_ack = 1;
      tick();
    end
    ireq_ack = 0;
    iresp_valid = 1; iresp_data = 32'hdead_beef;
    tick();
    iresp_valid = 0;
    for (int i = 0; i < 5 && !ireq_valid; i++) tick();
    n_cmp++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0100) begin n_bad++; $display("FAIL rreq_new_addr: got v=%b a=%h expected v=1 a=80000100", ireq_valid, ireq_addr); end
    n_cmp++; if (count !== 0) begin n_bad++; $display("FAIL rreq_dropped: got %0d expected 0", count); end
    for (int i = 0; i < 8 && !out_valid; i++) bus_run(1);
    n_cmp++; if (out_pc !== 64'h8000_0100 || out_instr !== instr_of(64'h8000_0100)) begin n_bad++; $display("FAIL rreq_head: got %h/%h expected 80000100/%h", out_pc, out_instr, instr_of(64'h8000_0100)); end
  endtask

  task automatic test_redirect_resp();
    do_reset();
    for (int i = 0; i < 10 && count != 1; i++) bus_run(1);
    ireq_ack = 1;
    tick();
    ireq_ack = 0;
    iresp_valid = 1; iresp_data = 32'h1111_2222; out_ready = 1;
    redirect_valid = 1; redirect_pc = 64'h8000_2002;
    tick();
    iresp_valid = 0; redirect_valid = 0; out_ready = 0;
    n_cmp++; if (count !== 0) begin n_bad++; $display("FAIL rresp_count: got %0d expected 0", count); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rresp_out_valid: got %b expected 0", out_valid); end
    for (int i = 0; i < 5 && !ireq_valid; i++) tick();
    n_cmp++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_2000) begin n_bad++; $display("FAIL rresp_new_addr: got v=%b a=%h expected v=1 a=80002000", ireq_valid, ireq_addr); end
    for (int i = 0; i < 8 && !out_valid; i++) bus_run(1);
    n_cmp++; if (out_pc !== 64'h8000_2000) begin n_bad++; $display("FAIL rresp_head: got %h expected 80002000", out_pc); end
  endtask

  task automatic test_full_wrap();
    logic [63:0] exp;
    int pops;
    do_reset();
    bus_run(30);
    exp = RESET_PC; pops = 0;
    for (int c = 0; c < 300 && pops < 20; c++) begin
      out_ready = (count == CW'(DEPTH));
      if (out_ready) begin
        n_cmp++; if (out_pc !== exp || out_instr !== instr_of(exp)) begin n_bad++; $display("FAIL wrap_head: got %h/%h expected %h/%h", out_pc, out_instr, exp, instr_of(exp)); end
        exp += 4; pops++;
      end
      n_cmp++; if (count < CW'(DEPTH - 1) || count > CW'(DEPTH)) begin n_bad++; $display("FAIL wrap_count: got %0d expected %0d or %0d", count, DEPTH - 1, DEPTH); end
      bus_run(1);
    end
    out_ready = 0;
    n_cmp++; if (pops !== 20) begin n_bad++; $display("FAIL wrap_pops: got %0d expected 20", pops); end
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    bus_run(4);
    n_cmp++; if (count !== 1 || !bus_pend) begin n_bad++; $display("FAIL rwait_setup: got count=%0d pend=%b expected 1 1", count, bus_pend); end
    reset = 1; bus_pend = 0;
    tick();
    reset = 0;
    n_cmp++; if (count !== 0 || out_valid !== 1'b0 || ireq_valid !== 1'b0) begin n_bad++; $display("FAIL rwait_state: got count=%0d ov=%b rv=%b expected 0 0 0", count, out_valid, ireq_valid); end
    tick();
    n_cmp++; if (ireq_valid !== 1'b1 || ireq_addr !== RESET_PC) begin n_bad++; $display("FAIL rwait_addr: got v=%b a=%h expected v=1 a=%h", ireq_valid, ireq_addr, RESET_PC); end
  endtask

  task automatic test_random();
    logic [95:0] q[$];
    logic [63:0] mpc, held_addr, resp_addr, rpc, exp_addr;
    logic [31:0] resp_data;
    bit outst, resp_stale, held_stale, ev_ack, ev_resp, ev_redir, ev_pop;
    int delay, idle_run;
    do_reset();
    mpc = RESET_PC; held_addr = '0; resp_addr = '0; resp_data = '0;
    outst = 0; resp_stale = 0; held_stale = 0; delay = 0; idle_run = 0;
    for (int c = 0; c < 4000; c++) begin
      n_cmp++; if (count !== CW'(q.size())) begin n_bad++; $display("FAIL rand_count @%0d: got %0d expected %0d", c, count, q.size()); end
      n_cmp++; if (out_valid !== (q.size() != 0)) begin n_bad++; $display("FAIL rand_out_valid @%0d: got %b expected %b", c, out_valid, q.size() != 0); end
      if (q.size() != 0) begin
        n_cmp++; if ({out_pc, out_instr} !== q[0]) begin n_bad++; $display("FAIL rand_head @%0d: got %h expected %h", c, {out_pc, out_instr}, q[0]); end
      end
      exp_addr = held_stale ? held_addr : mpc;
      if (ireq_valid) begin
        n_cmp++; if (ireq_addr !== exp_addr) begin n_bad++; $display("FAIL rand_req_addr @%0d: got %h expected %h", c, ireq_addr, exp_addr); end
      end
      if (!ireq_valid && !outst && q.size() < DEPTH) idle_run++; else idle_run = 0;
      n_cmp++; if (idle_run > 3) begin n_bad++; $display("FAIL rand_stall @%0d: idle for %0d cycles, expected at most 3", c, idle_run); end

      ev_resp  = outst && (delay == 0);
      if (outst && delay > 0) delay--;
      ev_ack   = ireq_valid && ($urandom_range(0, 2) != 0);
      ev_redir = ($urandom_range(0, 39) == 0);
      out_ready = ($urandom_range(0, 9) < 6);
      ev_pop   = out_valid && out_ready && !ev_redir;
      if ($urandom_range(0, 3) == 0) rpc = {60'hFFFF_FFFF_FFFF_FFF, 4'($urandom)};
      else rpc = {32'h0, $urandom};
      ireq_ack = ev_ack; iresp_valid = ev_resp; iresp_data = resp_data;
      redirect_valid = ev_redir; redirect_pc = rpc;

      if (ev_pop) void'(q.pop_front());
      if (ev_resp) begin
        outst = 0;
        if (!resp_stale && !ev_redir) q.push_back({resp_addr, resp_data});
      end
      if (ev_ack) begin
        outst = 1; delay = $urandom_range(0, 3);
        resp_addr = exp_addr; resp_data = $urandom;
        resp_stale = held_stale || ev_redir;
        if (!resp_stale) mpc += 4;
        held_stale = 0;
      end else if (ireq_valid && ev_redir && !held_stale) begin
        held_stale = 1; held_addr = mpc;
      end
      if (ev_redir) begin
        q.delete();
        mpc = rpc & ~64'd3;
        if (outst) resp_stale = 1;
        idle_run = 0;
      end
      tick();
    end
    ireq_ack = 0; iresp_valid = 0; redirect_valid = 0; out_ready = 0;
  endtask

  initial begin
    #500_000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_req();
    test_redirect_resp();
    test_full_wrap();
    test_reset_in_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
